// File: rtl/addsub_pkg.sv
// Shared types and constants for the add/sub arbiter.
// The entry record is sized for the widest legal id (NREQ up to 8) and
// tag (up to ADDSUB_TAG_MAX_W bits); narrower instances zero-extend into it.
// Optional flag fields exist only when ADDSUB_ARB_FLAGS_EN is defined.
package addsub_pkg;

   localparam int ADDSUB_FIFO_DEPTH = 2;
   localparam int ADDSUB_PTR_W      = 1;
   localparam int ADDSUB_CNT_W      = 2;
   localparam int ADDSUB_ID_MAX_W   = 3;
   localparam int ADDSUB_TAG_MAX_W  = 16;

   typedef struct packed {
      logic [ADDSUB_ID_MAX_W-1:0]  id;
      logic [ADDSUB_TAG_MAX_W-1:0] tag;
      logic [31:0]                 sum;
      logic                        cout;
`ifdef ADDSUB_ARB_FLAGS_EN
      logic                        zero;
      logic                        neg;
      logic                        ovf;
`endif
   } addsub_entry_t;

   // Advance a FIFO pointer, wrapping from the last slot back to 0.
   function automatic logic [ADDSUB_PTR_W-1:0] addsub_ptr_inc(input logic [ADDSUB_PTR_W-1:0] p);
      return (p == ADDSUB_PTR_W'(ADDSUB_FIFO_DEPTH - 1)) ? '0 : p + ADDSUB_PTR_W'(1);
   endfunction

endpackage

// File: rtl/addsub_rr_pick.sv
// Combinational round-robin priority picker. Scans valid upward from ptr
// with wrap-around; the first set index wins. grant is one-hot or zero.
module addsub_rr_pick #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] valid,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  winner,
   output logic            any
);

   int idx;

   // Rotating priority scan starting at ptr.
   always_comb begin
      grant  = '0;
      winner = '0;
      any    = 1'b0;
      idx    = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!any && valid[idx]) begin
            any         = 1'b1;
            grant[idx]  = 1'b1;
            winner      = IDW'(idx);
         end
      end
   end

endmodule

// File: rtl/kogge_stone_adder_subtractor_32b.sv
// 32-bit Kogge-Stone adder/subtractor: sum = a + (b ^ {32{sub}}) + sub.
// The carry-in (sub) is folded into bit 0's generate so the prefix tree
// delivers every carry, including cout, in five parallel-prefix levels.
module kogge_stone_adder_subtractor_32b (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        sub,
   output logic [31:0] sum,
   output logic        cout
);

   logic [31:0] bx;
   logic [31:0] hs;
   logic [31:0] g0, g1, g2, g3, g4, g5;
   logic [31:0] p0, p1, p2, p3, p4;

   assign bx = b ^ {32{sub}};
   assign hs = a ^ bx;

   // Bit-level generate/propagate, with the carry-in merged into bit 0.
   always_comb begin
      g0    = a & bx;
      g0[0] = (a[0] & bx[0]) | (hs[0] & sub);
      p0    = hs;
   end

   // Prefix levels: span doubles each level; low bits pass through unchanged.
   assign g1 = g0 | (p0 & (g0 << 1));
   assign p1 = p0 & ((p0 << 1) | 32'h0000_0001);
   assign g2 = g1 | (p1 & (g1 << 2));
   assign p2 = p1 & ((p1 << 2) | 32'h0000_0003);
   assign g3 = g2 | (p2 & (g2 << 4));
   assign p3 = p2 & ((p2 << 4) | 32'h0000_000F);
   assign g4 = g3 | (p3 & (g3 << 8));
   assign p4 = p3 & ((p3 << 8) | 32'h0000_00FF);
   assign g5 = g4 | (p4 & (g4 << 16));

   // g5[i] is the carry out of bit i; carry into bit 0 is sub.
   assign sum  = hs ^ {g5[30:0], sub};
   assign cout = g5[31];

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one 32-bit add/sub unit between NREQ
// requesters. The winner's operation is computed in the accept cycle and
// queued, with requester id and tag, in a 2-entry FIFO feeding the response
// port. Optional macro ADDSUB_ARB_FLAGS_EN adds rsp_zero/rsp_neg/rsp_ovf.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A requester that is not yet accepted keeps valid and its
// operands stable. req_ready depends only on req_valid and internal state;
// rsp_valid and rsp_* depend only on registers, never on rsp_ready or req_*.
module addsub_arbiter
   import addsub_pkg::*;
#(
   parameter  int NREQ  = 4,
   parameter  int TAG_W = 4,
   localparam int IDW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*32-1:0]    req_a,
   input  logic [NREQ*32-1:0]    req_b,
   input  logic [NREQ-1:0]       req_sub,
   input  logic [NREQ*TAG_W-1:0] req_tag,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [TAG_W-1:0]      rsp_tag,
   output logic [31:0]           rsp_sum,
   output logic                  rsp_cout
`ifdef ADDSUB_ARB_FLAGS_EN
   ,
   output logic                  rsp_zero,
   output logic                  rsp_neg,
   output logic                  rsp_ovf
`endif
);

   logic [IDW-1:0]          ptr;
   logic [IDW-1:0]          winner;
   logic [NREQ-1:0]         grant;
   logic                    any;
   logic [ADDSUB_PTR_W-1:0] rd;
   logic [ADDSUB_PTR_W-1:0] wr;
   logic [ADDSUB_CNT_W-1:0] cnt;
   addsub_entry_t           mem [ADDSUB_FIFO_DEPTH];
   addsub_entry_t           new_entry;
   addsub_entry_t           head;
   logic [31:0]             op_a;
   logic [31:0]             op_b;
   logic                    op_sub;
   logic [TAG_W-1:0]        op_tag;
   logic [31:0]             sum;
   logic                    cout;
   logic                    has_room;
   logic                    push;
   logic                    pop;
   logic                    head_unused;

   addsub_rr_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_pick (
      .valid  (req_valid),
      .ptr    (ptr),
      .grant  (grant),
      .winner (winner),
      .any    (any)
   );

   // Ready comes from registered occupancy only, so it never sees rsp_ready.
   assign has_room  = (cnt < ADDSUB_CNT_W'(ADDSUB_FIFO_DEPTH));
   assign req_ready = has_room ? grant : '0;
   assign push      = has_room & any;
   assign rsp_valid = (cnt != '0);
   assign pop       = rsp_valid & rsp_ready;

   // Route the winner's operands and tag to the shared adder.
   always_comb begin
      op_a   = req_a[32*winner +: 32];
      op_b   = req_b[32*winner +: 32];
      op_sub = req_sub[winner];
      op_tag = req_tag[TAG_W*winner +: TAG_W];
   end

   kogge_stone_adder_subtractor_32b u_adder (
      .a    (op_a),
      .b    (op_b),
      .sub  (op_sub),
      .sum  (sum),
      .cout (cout)
   );

   // Assemble the record that is pushed on accept.
   always_comb begin
      new_entry      = '0;
      new_entry.id   = ADDSUB_ID_MAX_W'(winner);
      new_entry.tag  = ADDSUB_TAG_MAX_W'(op_tag);
      new_entry.sum  = sum;
      new_entry.cout = cout;
`ifdef ADDSUB_ARB_FLAGS_EN
      new_entry.zero = (sum == 32'd0);
      new_entry.neg  = sum[31];
      new_entry.ovf  = (op_a[31] == (op_b[31] ^ op_sub)) && (sum[31] != op_a[31]);
`endif
   end

   // Priority pointer, FIFO pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
         rd  <= '0;
         wr  <= '0;
         cnt <= '0;
      end else begin
         if (push) begin
            wr  <= addsub_ptr_inc(wr);
            ptr <= (winner == IDW'(NREQ - 1)) ? '0 : winner + IDW'(1);
         end
         if (pop) begin
            rd <= addsub_ptr_inc(rd);
         end
         case ({push, pop})
            2'b10:   cnt <= cnt + ADDSUB_CNT_W'(1);
            2'b01:   cnt <= cnt - ADDSUB_CNT_W'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Result storage; contents are only observed through the masked head.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr] <= new_entry;
      end
   end

   // Head of queue, forced to zero while empty.
   always_comb begin
      head = rsp_valid ? mem[rd] : '0;
   end

   assign rsp_id      = head.id[IDW-1:0];
   assign rsp_tag     = head.tag[TAG_W-1:0];
   assign rsp_sum     = head.sum;
   assign rsp_cout    = head.cout;
   assign head_unused = ^{head.id, head.tag};
`ifdef ADDSUB_ARB_FLAGS_EN
   assign rsp_zero    = head.zero;
   assign rsp_neg     = head.neg;
   assign rsp_ovf     = head.ovf;
`endif

endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter (NREQ=4, TAG_W=4). A reference
// model keeps the expected response queue and a round-robin pointer derived
// from "next index after the last accepted requester".
module tb_addsub_arbiter;

   localparam int NREQ  = 4;
   localparam int TAG_W = 4;
   localparam int IDW   = 2;
`ifdef ADDSUB_ARB_FLAGS_EN
   localparam int EW = IDW + TAG_W + 33 + 3;
`else
   localparam int EW = IDW + TAG_W + 33;
`endif

   logic                  clk;
   logic                  rst_n;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*32-1:0]    req_a;
   logic [NREQ*32-1:0]    req_b;
   logic [NREQ-1:0]       req_sub;
   logic [NREQ*TAG_W-1:0] req_tag;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [IDW-1:0]        rsp_id;
   logic [TAG_W-1:0]      rsp_tag;
   logic [31:0]           rsp_sum;
   logic                  rsp_cout;
   logic [EW-1:0]         rsp_word;
`ifdef ADDSUB_ARB_FLAGS_EN
   logic                  rsp_zero;
   logic                  rsp_neg;
   logic                  rsp_ovf;
   assign rsp_word = {rsp_id, rsp_tag, rsp_cout, rsp_sum, rsp_zero, rsp_neg, rsp_ovf};
`else
   assign rsp_word = {rsp_id, rsp_tag, rsp_cout, rsp_sum};
`endif

   logic [31:0]      a_v   [NREQ];
   logic [31:0]      b_v   [NREQ];
   logic             sub_v [NREQ];
   logic [TAG_W-1:0] tag_v [NREQ];

   logic [EW-1:0] exp_q[$];
   int            m_ptr;
   int            last_acc;
   int            checks;
   int            errors;

   addsub_arbiter #(.NREQ(NREQ), .TAG_W(TAG_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_sub   (req_sub),
      .req_tag   (req_tag),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_tag   (rsp_tag),
      .rsp_sum   (rsp_sum),
      .rsp_cout  (rsp_cout)
`ifdef ADDSUB_ARB_FLAGS_EN
      ,
      .rsp_zero  (rsp_zero),
      .rsp_neg   (rsp_neg),
      .rsp_ovf   (rsp_ovf)
`endif
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pack per-requester stimulus into the flat buses.
   always_comb begin
      req_a   = '0;
      req_b   = '0;
      req_sub = '0;
      req_tag = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_a[32*i +: 32]       = a_v[i];
         req_b[32*i +: 32]       = b_v[i];
         req_sub[i]              = sub_v[i];
         req_tag[TAG_W*i +: TAG_W] = tag_v[i];
      end
   end

   // ---------------- reference model ----------------
   function automatic logic [EW-1:0] make_entry(input int id, input logic [TAG_W-1:0] tag,
                                                input logic [31:0] a, input logic [31:0] b,
                                                input logic sub);
      logic [31:0] s;
      logic        c;
      longint      sa, sb, sr;
      s  = sub ? a - b : a + b;
      c  = sub ? (a >= b) : ((longint'(a) + longint'(b)) >= 64'sh1_0000_0000);
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sr = sub ? sa - sb : sa + sb;
`ifdef ADDSUB_ARB_FLAGS_EN
      return {IDW'(id), tag, c, s, (s == 32'd0), s[31],
              ((sr > 64'sd2147483647) || (sr < -64'sd2147483648))};
`else
      sr = sr;
      return {IDW'(id), tag, c, s};
`endif
   endfunction

   function automatic int model_winner();
      for (int k = 0; k < NREQ; k++) begin
         int i;
         i = (m_ptr + k) % NREQ;
         if (req_valid[i]) return i;
      end
      return -1;
   endfunction

   function automatic logic [NREQ-1:0] exp_ready();
      logic [NREQ-1:0] r;
      int w;
      r = '0;
      w = model_winner();
      if (w >= 0 && exp_q.size() < 2) r[w] = 1'b1;
      return r;
   endfunction

   function automatic logic [EW-1:0] exp_head();
      return (exp_q.size() != 0) ? exp_q[0] : '0;
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h7FFF_FFFF;
         3:       return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   // ---------------- driver tasks ----------------
   task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [TAG_W-1:0] t);
      a_v[i] = a; b_v[i] = b; sub_v[i] = s; tag_v[i] = t;
      req_valid[i] = 1'b1;
   endtask

   task automatic rand_req(input int i);
      set_req(i, pick_operand(), pick_operand(), 1'($urandom_range(0, 1)),
              TAG_W'($urandom_range(0, 15)));
   endtask

   // Apply the model's view of the coming edge, then move to the next negedge.
   task automatic advance();
      int w;
      bit acc, pp;
      w   = model_winner();
      acc = (w >= 0) && (exp_q.size() < 2);
      pp  = (exp_q.size() > 0) && rsp_ready;
      if (pp) void'(exp_q.pop_front());
      if (acc) begin
         exp_q.push_back(make_entry(w, tag_v[w], a_v[w], b_v[w], sub_v[w]));
         m_ptr = (w + 1) % NREQ;
      end
      last_acc = acc ? w : -1;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         a_v[i] = '0; b_v[i] = '0; sub_v[i] = 1'b0; tag_v[i] = '0;
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      m_ptr = 0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rsp_valid); end
      checks++; if (rsp_word !== '0) begin errors++; $display("FAIL reset_rsp got %h exp 0", rsp_word); end
      checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_ready got %b exp 0", req_ready); end
      req_valid = 4'b1010;
      #1;
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL reset_first_grant got %b exp 0010", req_ready); end
      req_valid = '0;
      @(negedge clk);
   endtask

   task automatic test_single_add();
      rsp_ready = 1'b0;
      set_req(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 4'hA);
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL add_ready got %b exp 0001", req_ready); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_valid_early got %b exp 0", rsp_valid); end
      advance();
      req_valid = '0;
      #1;
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %b exp 1", rsp_valid); end
      checks++; if (rsp_sum !== 32'h0 || rsp_cout !== 1'b1) begin errors++; $display("FAIL add_result got %h/%b exp 0/1", rsp_sum, rsp_cout); end
      checks++; if (rsp_id !== 2'd0 || rsp_tag !== 4'hA) begin errors++; $display("FAIL add_id_tag got %0d/%h exp 0/a", rsp_id, rsp_tag); end
      checks++; if (rsp_word !== exp_head()) begin errors++; $display("FAIL add_word got %h exp %h", rsp_word, exp_head()); end
      rsp_ready = 1'b1;
      advance();
      #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_drained got %b exp 0", rsp_valid); end
   endtask

   task automatic test_subtract();
      logic [31:0] ta [3];
      logic [31:0] tb [3];
      logic        ts [3];
      logic [31:0] es [3];
      logic        ec [3];
      ta = '{32'd5, 32'd7, 32'h7FFF_FFFF};
      tb = '{32'd7, 32'd5, 32'd1};
      ts = '{1'b1, 1'b1, 1'b0};
      es = '{32'hFFFF_FFFE, 32'h0000_0002, 32'h8000_0000};
      ec = '{1'b0, 1'b1, 1'b0};
      rsp_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         set_req(2, ta[k], tb[k], ts[k], TAG_W'(k + 3));
         #1;
         checks++; if (req_ready !== exp_ready()) begin errors++; $display("FAIL sub_ready[%0d] got %b exp %b", k, req_ready, exp_ready()); end
         advance();
         req_valid = '0;
         #1;
         checks++; if (rsp_sum !== es[k] || rsp_cout !== ec[k] || rsp_id !== 2'd2) begin
            errors++; $display("FAIL sub_result[%0d] got %h/%b/%0d exp %h/%b/2", k, rsp_sum, rsp_cout, rsp_id, es[k], ec[k]);
         end
         checks++; if (rsp_word !== exp_head()) begin errors++; $display("FAIL sub_word[%0d] got %h exp %h", k, rsp_word, exp_head()); end
`ifdef ADDSUB_ARB_FLAGS_EN
         if (k == 2) begin
            checks++; if (rsp_ovf !== 1'b1 || rsp_neg !== 1'b1 || rsp_zero !== 1'b0) begin
               errors++; $display("FAIL sub_flags got z%b n%b o%b exp z0 n1 o1", rsp_zero, rsp_neg, rsp_ovf);
            end
         end
`endif
         advance();
      end
      #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL sub_drained got %b exp 0", rsp_valid); end
   endtask

   task automatic test_round_robin();
      logic [NREQ-1:0] oh;
      do_reset();
      rsp_ready = 1'b1;
      for (int i = 0; i < NREQ; i++) rand_req(i);
      for (int k = 0; k < 5; k++) begin
         #1;
         oh = '0;
         oh[k % NREQ] = 1'b1;
         checks++; if (req_ready !== oh || req_ready !== exp_ready()) begin errors++; $display("FAIL rr_grant[%0d] got %b exp %b", k, req_ready, oh); end
         checks++; if (rsp_valid !== (k > 0) || rsp_word !== exp_head()) begin errors++; $display("FAIL rr_rsp[%0d] got %b/%h exp %h", k, rsp_valid, rsp_word, exp_head()); end
         advance();
         if (last_acc >= 0) rand_req(last_acc);
      end
      req_valid = '0;
      repeat (2) begin
         #1;
         checks++; if (rsp_word !== exp_head() || rsp_valid !== (exp_q.size() != 0)) begin errors++; $display("FAIL rr_drain got %h exp %h", rsp_word, exp_head()); end
         advance();
      end
   endtask

   task automatic test_stall();
      int dut_acc;
      dut_acc   = 0;
      rsp_ready = 1'b0;
      for (int i = 0; i < NREQ; i++) rand_req(i);
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++; if (req_ready !== exp_ready()) begin errors++; $display("FAIL stall_ready[%0d] got %b exp %b", k, req_ready, exp_ready()); end
         checks++; if (rsp_word !== exp_head()) begin errors++; $display("FAIL stall_rsp[%0d] got %h exp %h", k, rsp_word, exp_head()); end
         if ((req_valid & req_ready) != '0) dut_acc++;
         advance();
         if (last_acc >= 0) rand_req(last_acc);
      end
      #1;
      checks++; if (dut_acc !== 2) begin errors++; $display("FAIL stall_accepts got %0d exp 2", dut_acc); end
      checks++; if (req_ready !== '0) begin errors++; $display("FAIL stall_full_ready got %b exp 0", req_ready); end
      rsp_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         #1;
         checks++; if (req_ready !== exp_ready()) begin errors++; $display("FAIL resume_ready[%0d] got %b exp %b", k, req_ready, exp_ready()); end
         checks++; if (rsp_valid !== (exp_q.size() != 0) || rsp_word !== exp_head()) begin errors++; $display("FAIL resume_rsp[%0d] got %h exp %h", k, rsp_word, exp_head()); end
         advance();
         if (last_acc >= 0) rand_req(last_acc);
      end
      req_valid = '0;
      repeat (3) advance();
   endtask

   task automatic test_back_to_back();
      int r;
      do_reset();
      rsp_ready = 1'b1;
      rand_req(1);
      advance();
      req_valid = '0;
      for (int k = 0; k < 10; k++) begin
         r = $urandom_range(0, NREQ - 1);
         req_valid = '0;
         rand_req(r);
         #1;
         checks++; if (rsp_valid !== 1'b1 || rsp_word !== exp_head()) begin errors++; $display("FAIL b2b_rsp[%0d] got %b/%h exp 1/%h", k, rsp_valid, rsp_word, exp_head()); end
         checks++; if (req_ready !== exp_ready()) begin errors++; $display("FAIL b2b_ready[%0d] got %b exp %b", k, req_ready, exp_ready()); end
         advance();
      end
      req_valid = '0;
      #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_word !== exp_head()) begin errors++; $display("FAIL b2b_last got %h exp %h", rsp_word, exp_head()); end
      advance();
      #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b exp 0", rsp_valid); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i] && $urandom_range(0, 2) == 0) rand_req(i);
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         #1;
         checks++; if (req_ready !== exp_ready()) begin errors++; $display("FAIL rand_ready[%0d] got %b exp %b", n, req_ready, exp_ready()); end
         checks++; if (rsp_valid !== (exp_q.size() != 0) || rsp_word !== exp_head()) begin errors++; $display("FAIL rand_rsp[%0d] got %b/%h exp %h", n, rsp_valid, rsp_word, exp_head()); end
         advance();
         if (last_acc >= 0) req_valid[last_acc] = 1'b0;
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      repeat (3) advance();
   endtask

   task automatic test_mid_reset();
      rsp_ready = 1'b0;
      for (int i = 0; i < NREQ; i++) rand_req(i);
      repeat (2) begin
         advance();
         if (last_acc >= 0) rand_req(last_acc);
      end
      #1;
      checks++; if (rsp_valid !== 1'b1 || req_ready !== '0) begin errors++; $display("FAIL mrst_full got %b/%b exp 1/0000", rsp_valid, req_ready); end
      #1;
      rst_n = 1'b0;
      exp_q.delete();
      m_ptr = 0;
      #1;
      checks++; if (rsp_valid !== 1'b0 || rsp_word !== '0) begin errors++; $display("FAIL mrst_flush got %b/%h exp 0/0", rsp_valid, rsp_word); end
      @(negedge clk);
      rst_n = 1'b1;
      req_valid = 4'b1100;
      #1;
      checks++; if (req_ready !== 4'b0100 || req_ready !== exp_ready()) begin errors++; $display("FAIL mrst_first_grant got %b exp 0100", req_ready); end
      rsp_ready = 1'b1;
      advance();
      req_valid = '0;
      #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_word !== exp_head()) begin errors++; $display("FAIL mrst_rsp got %h exp %h", rsp_word, exp_head()); end
      advance();
      #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mrst_no_stale got %b exp 0", rsp_valid); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      checks    = 0;
      errors    = 0;
      last_acc  = -1;
      m_ptr     = 0;
      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b0;
      test_reset();
      test_single_add();
      test_subtract();
      test_round_robin();
      test_stall();
      test_back_to_back();
      test_random();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/addsub_arbiter.md
# addsub_arbiter

Round-robin arbiter that shares one `kogge_stone_adder_subtractor_32b` instance between NREQ requesters, such as the ALU, address generation and the branch-target unit. Each requester presents operands, an add/sub select and a tag over a valid/ready handshake. The winner's operation is computed in the same cycle. Results are queued in a 2-entry output FIFO and returned with the requester ID and tag over a valid/ready response port.

## Interface
- NREQ, 4: number of requesters, legal range 2..8; IDW = $clog2(NREQ)
- TAG_W, 4: opaque tag width, at least 1
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- req_a  in  NREQ*32  operand A, requester i at [32i+31:32i]
- req_b  in  NREQ*32  operand B, same packing
- req_sub  in  NREQ  0 = add, 1 = subtract (A - B)
- req_tag  in  NREQ*TAG_W  tag, packed
- rsp_valid  out  1  FIFO head valid
- rsp_ready  in  1  consumer accept
- rsp_id  out  IDW  requester index of head entry
- rsp_tag  out  TAG_W  tag of head entry
- rsp_sum  out  32  result
- rsp_cout  out  1  adder carry-out; for subtract, 1 = no borrow

## Operation
- Arbitration
  - Combinational scan of req_valid starting at priority pointer ptr, ascending with wrap. The first valid index is the winner.
  - The winner's a/b/sub drive the shared adder (s = sub).
- Accept and push
  - req_ready[winner] = 1 only when cnt < 2. All other req_ready bits are 0.
  - req_ready never depends on rsp_ready or on any other combinational input except req_valid.
  - On accept (req_valid & req_ready): push {winner, tag, sum, cout} into the FIFO, and set ptr <= (winner+1) mod NREQ.
  - If there is no accept, ptr holds.
- FIFO
  - 2 entries, read pointer rd, write pointer wr, count cnt in 0..2.
  - Pop on rsp_valid & rsp_ready.
  - Simultaneous push and pop at cnt = 1 leaves cnt = 1.
  - At cnt = 2 no push is possible (req_ready = 0) regardless of pop. The pop proceeds and cnt becomes 1.
  - At cnt = 0 a pop cannot occur (rsp_valid = 0).
  - Both pointers wrap 1 -> 0.
- Requests are not latched internally. A requester that is not granted must hold valid and its operands stable until accepted. The block never drops or reorders accepted requests; responses are in accept order.
- Fairness: a continuously valid requester is accepted within NREQ accepts.

## Timing
- Reset, asynchronous on rst_n low:
  - cnt = 0, rd = wr = 0, ptr = 0
  - rsp_valid = 0, rsp_id = 0, rsp_tag = 0, rsp_sum = 0, rsp_cout = 0
  - Storage contents are don't-care but outputs are forced to 0 while empty.
- Reset asserted mid-operation discards all queued results. No response for them is ever produced.
- Latency: accept at edge N makes the result visible on rsp_* after edge N. rsp_valid is high in the following cycle when the FIFO was empty.
- Throughput is 1 result/cycle when rsp_ready is held high.
- A stall of rsp_ready low fills the FIFO after 2 accepts, then req_ready drops to 0.
- rsp_* are driven from registers and mux only, with no combinational path from req_* inputs.

## Configuration
- ADDSUB_ARB_FLAGS_EN defined: adds outputs rsp_zero, rsp_neg and rsp_ovf, each 1 bit, stored per FIFO entry and reset to 0.
  - zero = (sum == 0)
  - neg = sum[31]
  - ovf = signed overflow of a + (b ^ {32{sub}}) + sub: operand sign bits equal and sum sign differs.
- Undefined: the ports and storage are absent, and all other behaviour is identical.

## Structure
- Shared package addsub_pkg holds:
  - the entry record typedef {id, tag, sum, cout[, flags]}
  - the FIFO depth constant ADDSUB_FIFO_DEPTH = 2
  - the pointer and count widths
- One sub-module: addsub_rr_pick, a combinational round-robin priority picker taking req_valid and ptr and producing the one-hot grant and the winner index.
- The adder is instantiated once, directly in the top.

## Test plan
- Single requester 0: add 0xFFFFFFFF + 0x00000001 -> rsp_sum 0x00000000, rsp_cout 1, rsp_id 0, tag echoed, rsp_valid one cycle after accept.
- Subtract from requester 2: 5 - 7 -> 0xFFFFFFFE with cout 0. 7 - 5 -> 0x00000002 with cout 1. With the flag macro, 0x7FFFFFFF + 1 -> ovf 1, neg 1.
- All 4 requesters valid with rsp_ready = 1 -> grants in order 0, 1, 2, 3, 0, one accept per cycle, and rsp_id follows the same sequence.
- rsp_ready = 0 with all valid -> exactly 2 accepts, then req_ready = 0. Raising rsp_ready drains in accept order, and grants resume with the next round-robin index.
- cnt = 1 with a simultaneous push and pop for 10 cycles -> cnt stays 1, no loss, order preserved.
- rst_n pulsed low with cnt = 2 -> rsp_valid 0 immediately. After release, ptr = 0 and the first grant goes to the lowest valid index.
